// File: rtl/iterative_logic_shift_unit_pkg.sv
// Shared types for the iterative logic/shift unit: op codes, FSM states and
// the shift-amount saturation check.
package ilsu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_NOT = 3'b011,
    OP_SLL = 3'b100,
    OP_SRL = 3'b101,
    OP_SRA = 3'b110,
    OP_ROL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  localparam int MAX_WIDTH = 64;

  // An amount of WIDTH or more shifts every bit out, so it resolves in one step.
  function automatic logic shamt_saturates(input logic [MAX_WIDTH-1:0] amt, input int width);
    return (amt >= 64'(width));
  endfunction

endpackage

// File: rtl/iterative_logic_shift_unit_if.sv
// Start/done request bus between the ALU control FSM (master) and the
// iterative logic/shift unit (slave).
interface iterative_logic_shift_unit_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (output start, op, a, b, input busy, done, result);
  modport slave  (input start, op, a, b, output busy, done, result);
endinterface

// File: rtl/iterative_logic_shift_unit_bitwise.sv
// Combinational bitwise stage: AND/OR/XOR/NOT selected by the low op bits.
module ilsu_bitwise
  import ilsu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [1:0]       sel_i,
  output logic [WIDTH-1:0] y_o
);

  // Pure select among the four bitwise functions.
  always_comb begin
    y_o = '0;
    case (sel_i)
      2'b00:   y_o = a_i & b_i;
      2'b01:   y_o = a_i | b_i;
      2'b10:   y_o = a_i ^ b_i;
      2'b11:   y_o = ~a_i;
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/iterative_logic_shift_unit.sv
// Multi-cycle logic/shift unit, one bit position per clock for shifts.
// Optional rotate-left on op 111 is enabled by defining ILSU_ROTATE_EN.
module iterative_logic_shift_unit
  import ilsu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input logic                         clk,
  input logic                         rst_n,
  iterative_logic_shift_unit_if.slave bus
);

  state_e             state_q;
  op_e                op_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic [WIDTH-1:0]   result_q;
  logic               busy_q;
  logic               done_q;

  op_e                op_in_s;
  logic               sat_s;
  logic [SHAMT_W-1:0] b_low_s;
  logic [WIDTH-1:0]   logic_res_s;
  logic [WIDTH-1:0]   load_val_d;
  logic [SHAMT_W-1:0] load_cnt_d;
  logic               go_shift_d;
  logic [WIDTH-1:0]   step_val_d;

  assign op_in_s = op_e'(bus.op);
  assign sat_s   = shamt_saturates(MAX_WIDTH'(bus.b), WIDTH);
  assign b_low_s = bus.b[SHAMT_W-1:0];

`ifdef ILSU_ROTATE_EN
  logic [SHAMT_W-1:0] rol_amt_s;
  assign rol_amt_s = SHAMT_W'(bus.b % WIDTH);
`endif

  ilsu_bitwise #(.WIDTH(WIDTH)) u_bitwise (
    .a_i   (bus.a),
    .b_i   (bus.b),
    .sel_i (bus.op[1:0]),
    .y_o   (logic_res_s)
  );

  // Value, count and path chosen on the acceptance edge.
  always_comb begin
    load_val_d = bus.a;
    load_cnt_d = '0;
    go_shift_d = 1'b0;
    case (op_in_s)
      OP_AND, OP_OR, OP_XOR, OP_NOT: load_val_d = logic_res_s;
      OP_SLL, OP_SRL: begin
        if (sat_s) begin
          load_val_d = '0;
        end else begin
          load_cnt_d = b_low_s;
          go_shift_d = (b_low_s != '0);
        end
      end
      OP_SRA: begin
        if (sat_s) begin
          load_val_d = {WIDTH{bus.a[WIDTH-1]}};
        end else begin
          load_cnt_d = b_low_s;
          go_shift_d = (b_low_s != '0);
        end
      end
`ifdef ILSU_ROTATE_EN
      OP_ROL: begin
        load_cnt_d = rol_amt_s;
        go_shift_d = (rol_amt_s != '0);
      end
`else
      OP_ROL: load_val_d = '0;
`endif
      default: load_val_d = '0;
    endcase
  end

  // One-bit step applied in each SHIFT cycle.
  always_comb begin
    step_val_d = result_q;
    case (op_q)
      OP_SLL:  step_val_d = {result_q[WIDTH-2:0], 1'b0};
      OP_SRL:  step_val_d = {1'b0, result_q[WIDTH-1:1]};
      OP_SRA:  step_val_d = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
`ifdef ILSU_ROTATE_EN
      OP_ROL:  step_val_d = {result_q[WIDTH-2:0], result_q[WIDTH-1]};
`endif
      default: step_val_d = result_q;
    endcase
  end

  // Control FSM with registered busy/done/result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_AND;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_q     <= op_in_s;
            result_q <= load_val_d;
            cnt_q    <= load_cnt_d;
            busy_q   <= 1'b1;
            if (go_shift_d) begin
              state_q <= ST_SHIFT;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_SHIFT: begin
          result_q <= step_val_d;
          cnt_q    <= cnt_q - SHAMT_W'(1);
          if (cnt_q == SHAMT_W'(1)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_SHIFT;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: doc/iterative_logic_shift_unit.md
# iterative_logic_shift_unit

Parametrised, multi-cycle logic/shift unit. It succeeds the fixed 16-bit bitwise and shift blocks in the ALU with one operand-width parameter, a registered result and a start/done handshake. Shifts advance one bit position per clock, so the unit is small and its latency depends on the operand. It sits beside the adder and multiplier in the ALU datapath and is driven by the ALU control FSM.

## Interface
- `WIDTH`, 16: operand and result width in bits; must be ≥ 2.
- `SHAMT_W`, `$clog2(WIDTH)`: width of the effective shift-amount counter.
- `clk`, input, 1: the single clock; every register updates on the rising edge.
- `rst_n`, input, 1: asynchronous reset, active-low.
- `start`, input, 1: request. It is accepted only in IDLE.
- `op`, input, 3: operation code, sampled when `start` is accepted.
- `a`, input, WIDTH: first operand, or the value to shift.
- `b`, input, WIDTH: second operand for logic ops. For shifts it is the unsigned shift amount.
- `busy`, output, 1: high whenever the FSM is not in IDLE.
- `done`, output, 1: single-cycle pulse when `result` becomes valid.
- `result`, output, WIDTH: registered result. It holds its value until the next accepted `start`.

## Operation
- Op codes:
  - 000 AND; 001 OR; 010 XOR; 011 NOT (NOT uses `a` only).
  - 100 SLL; 101 SRL; 110 SRA; 111 ROL (rotate-left).
- FSM states are IDLE, SHIFT and DONE. Transitions:
  - IDLE → SHIFT when `start` is high, `op` is a shift, and the effective amount is non-zero.
  - IDLE → DONE on `start` in every other case.
  - SHIFT → DONE when the count reaches 1; the last bit shift happens on that edge.
  - DONE → IDLE unconditionally.
- On acceptance the unit captures `a` into `result`, `op` into a register, and the effective amount into the counter.
- For logic ops, `result` is loaded with the combinational result on the acceptance edge.
- Effective amount for SLL, SRL and SRA:
  - If `b` ≥ WIDTH (any bit above `SHAMT_W-1` set, or `b[SHAMT_W-1:0]` ≥ WIDTH), the shift saturates in one step on the acceptance edge.
  - Saturated SLL/SRL load 0. Saturated SRA loads WIDTH copies of `a[WIDTH-1]`.
- Effective amount for ROL is `b` mod WIDTH.
- Each SHIFT cycle moves `result` by one bit and decrements the counter:
  - SLL fills the LSB with 0.
  - SRL fills the MSB with 0.
  - SRA replicates the MSB.
  - ROL moves the old MSB into the LSB.
- `start` is ignored while `busy` is high, including in DONE. It does not queue.
- Operand inputs are ignored after acceptance, so they may change freely while the unit is busy.

## Timing
- Reset values: `busy` 0, `done` 0, `result` 0, state IDLE, counter 0.
- Reset asserted mid-operation aborts the operation immediately and returns these values. No `done` is produced.
- With `start` accepted at edge T:
  - Logic op, zero-amount shift or saturated shift: DONE is entered at T+1, so `done`=1 and `busy`=1 during cycle T+1.
  - Shift by n (1 ≤ n < WIDTH): SHIFT spans cycles T+1..T+n, and DONE is entered at T+n+1.
- `busy` is high from T+1 through the DONE cycle inclusive.
- The next `start` can be accepted no earlier than the cycle after DONE.
- `result` is stable and valid from the DONE cycle onward.

## Configuration
- Macro: `ILSU_ROTATE_EN`.
- When defined, op 111 performs ROL as described above.
- When undefined:
  - op 111 is an illegal code. It takes the logic path: `result` loads 0 and `done` pulses at T+1.
  - The rotate feedback path and the ROL modulo logic are not generated.

## Structure
- Shared package `ilsu_pkg`:
  - op-code enum (`OP_AND`…`OP_ROL`);
  - FSM state enum;
  - a helper function for the saturation check.
- One sub-module, `ilsu_bitwise`: combinational WIDTH-bit AND/OR/XOR/NOT selected by `op[1:0]`. It is instantiated once.

## Test plan
All scenarios use WIDTH=16.
- AND: `a`=0xF0F0, `b`=0xFF00, `start` at T → `result`=0xF000, `done` pulses at T+1 only.
- SLL: `a`=0x0001, `b`=4 → `busy` high T+1..T+5, `done` at T+5, `result`=0x0010.
- SRA then SRL: `a`=0x8000, `b`=3 → SRA gives 0xF000 and SRL gives 0x1000, each with `done` at T+4.
- Saturation:
  - SRA with `a`=0x8000, `b`=20 → 0xFFFF.
  - SRL with `b`=0x0100 → 0x0000.
  - Both with `done` at T+1.
- Busy and reset:
  - SLL with `b`=10; a second `start` at T+2 is ignored.
  - `rst_n` low at T+3 → `busy`, `done` and `result` are all 0 asynchronously, and there is no later `done`.
- ROL: `a`=0x8001, `b`=17.
  - With `ILSU_ROTATE_EN` → 0x0003, `done` at T+2.
  - Without the macro → 0x0000, `done` at T+1.
